// File: rtl/lc3_pkg.sv
// lc3_pkg: shared constants and state type for the LC-3 memory/IO controller
package lc3_pkg;
  localparam logic [15:0] MMIO_BASE = 16'hFE00;
  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;
  localparam logic [15:0] DSR = 16'hFE04;
  localparam logic [15:0] DDR = 16'hFE06;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_e;
endpackage

// File: rtl/lc3_mmio_regs.sv
// lc3_mmio_regs: keyboard buffer, display register and device read mux
module lc3_mmio_regs
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              dir_i,
  input  logic [7:0]        wdata_i,
  input  logic [7:0]        kb_char_i,
  input  logic              kb_valid_i,
  input  logic              dsp_ready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [7:0]        dsp_data_o,
  output logic              dsp_valid_o
);
  logic       kb_full_q, kb_ovf_q, kbdr_rd, ddr_wr;
  logic [7:0] kb_buf_q, dsp_q;
  logic [15:0] dev;
  always_comb begin
    kbdr_rd = done_i && !dir_i && addr_i == ADDR_W'(KBDR);
    ddr_wr = done_i && dir_i && addr_i == ADDR_W'(DDR);
    dev = addr_i == ADDR_W'(KBSR) ? {kb_full_q, kb_ovf_q, 14'b0} :
          addr_i == ADDR_W'(KBDR) ? {8'h00, kb_buf_q} :
          addr_i == ADDR_W'(DSR) ? {dsp_ready_i, 15'b0} : 16'h0000;
    rdata_o = DATA_W'(dev);
    dsp_valid_o = ddr_wr;
    // the new character is visible during the strobe and held afterwards
    dsp_data_o = ddr_wr ? wdata_i : dsp_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kb_full_q <= 1'b0;
      kb_ovf_q <= 1'b0;
      kb_buf_q <= 8'h00;
      dsp_q <= 8'h00;
    end else begin
      if (kb_valid_i && (!kb_full_q || kbdr_rd)) kb_buf_q <= kb_char_i;
      kb_full_q <= kb_valid_i || (kb_full_q && !kbdr_rd);
      kb_ovf_q <= !kbdr_rd && (kb_ovf_q || (kb_valid_i && kb_full_q));
      if (ddr_wr) dsp_q <= wdata_i;
    end
  end
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: MAR/MDR and multi-cycle RAM/MMIO access sequencer for the LC-3
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MEM_EN,
  input  logic              R_W,
  output logic [DATA_W-1:0] mdr_out,
  output logic              R,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        kb_char,
  input  logic              kb_valid,
  input  logic              dsp_ready,
  output logic [7:0]        dsp_data,
  output logic              dsp_valid
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  mem_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] mar_q, addr_q;
  logic [DATA_W-1:0] mdr_q, wdata_q, rdata_q, dev_rdata, rd_res;
  logic              dir_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (MEM_EN) begin
        state_d = mar_q >= ADDR_W'(MMIO_BASE) ? DONE : ACCESS;
        cnt_d = CW'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        state_d = cnt_q == '0 ? DONE : ACCESS;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (LD_MAR) mar_q <= ADDR_W'(bus_in);
      if (state_q == IDLE && MEM_EN) begin
        addr_q <= mar_q;
        dir_q <= R_W;
        wdata_q <= mdr_q;
      end
      if (state_q == ACCESS && cnt_q == '0) rdata_q <= mem_rdata;
      // a completing read takes priority over a bus load
      if (LD_MDR && R && !dir_q) mdr_q <= rd_res;
      else if (LD_MDR && !MEM_EN) mdr_q <= bus_in;
    end
  end
  assign rd_res = addr_q >= ADDR_W'(MMIO_BASE) ? dev_rdata : rdata_q;
  assign R = state_q == DONE;
  assign mem_en = state_q == ACCESS;
  assign mem_we = mem_en && dir_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mdr_out = mdr_q;
  lc3_mmio_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mmio (
    .clk(clk),
    .rst_n(rst_n),
    .done_i(R),
    .addr_i(addr_q),
    .dir_i(dir_q),
    .wdata_i(wdata_q[7:0]),
    .kb_char_i(kb_char),
    .kb_valid_i(kb_valid),
    .dsp_ready_i(dsp_ready),
    .rdata_o(dev_rdata),
    .dsp_data_o(dsp_data),
    .dsp_valid_o(dsp_valid)
  );
endmodule
